// File: rtl/quantizer.sv
// quantizer: divides a signed DCT coefficient by a per-position table entry.
// The result is rounded half away from zero and saturated to OUT_BIT bits,
// using a bit-serial restoring divider with a valid/ready handshake per sample.
// Optional feature macro: QUANT_TABLE_LOAD_EN adds a run-time writable table
// (tablo_* ports). Without it the table is the fixed JPEG luminance table.
module quantizer #(
    parameter int unsigned IN_BIT  = 16,
    parameter int unsigned OUT_BIT = 11
) (
    input  logic               clk_i,
    input  logic               rstn_i,
    input  logic [IN_BIT-1:0]  dct_veri_i,
    input  logic [2:0]         dct_veri_row_i,
    input  logic [2:0]         dct_veri_col_i,
    input  logic               dct_veri_gecerli_i,
    input  logic               dct_blok_son_i,
    output logic               dct_veri_hazir_o,
`ifdef QUANT_TABLE_LOAD_EN
    input  logic               tablo_yaz_i,
    input  logic [5:0]         tablo_adres_i,
    input  logic [7:0]         tablo_veri_i,
`endif
    output logic [OUT_BIT-1:0] zig_veri_o,
    output logic [2:0]         zig_veri_row_o,
    output logic [2:0]         zig_veri_col_o,
    output logic               zig_veri_gecerli_o,
    output logic               zig_blok_son_o,
    input  logic               zig_veri_hazir_i
);

    localparam int unsigned DW = IN_BIT + 1;
    localparam int unsigned CW = $clog2(DW);
    localparam int unsigned QW = 8;

    localparam logic [DW-1:0]      POS_LIM = DW'((1 << (OUT_BIT - 1)) - 1);
    localparam logic [DW-1:0]      NEG_LIM = DW'(1 << (OUT_BIT - 1));
    localparam logic [OUT_BIT-1:0] OUT_MAX = {1'b0, {(OUT_BIT - 1){1'b1}}};
    localparam logic [OUT_BIT-1:0] OUT_MIN = {1'b1, {(OUT_BIT - 1){1'b0}}};

    localparam logic [QW-1:0] DEF_TABLE [64] = '{
        8'd16, 8'd11, 8'd10, 8'd16, 8'd24,  8'd40,  8'd51,  8'd61,
        8'd12, 8'd12, 8'd14, 8'd19, 8'd26,  8'd58,  8'd60,  8'd55,
        8'd14, 8'd13, 8'd16, 8'd24, 8'd40,  8'd57,  8'd69,  8'd56,
        8'd14, 8'd17, 8'd22, 8'd29, 8'd51,  8'd87,  8'd80,  8'd62,
        8'd18, 8'd22, 8'd37, 8'd56, 8'd68,  8'd109, 8'd103, 8'd77,
        8'd24, 8'd35, 8'd55, 8'd64, 8'd81,  8'd104, 8'd113, 8'd92,
        8'd49, 8'd64, 8'd78, 8'd87, 8'd103, 8'd121, 8'd120, 8'd101,
        8'd72, 8'd92, 8'd95, 8'd98, 8'd112, 8'd100, 8'd103, 8'd99
    };

    typedef enum logic [1:0] {
        BOSTA,
        BOL,
        SONUC,
        CIKIS
    } state_t;

    state_t             state_q, state_d;
    logic [2:0]         row_q, row_d;
    logic [2:0]         col_q, col_d;
    logic               son_q, son_d;
    logic               neg_q, neg_d;
    logic [QW-1:0]      q_q, q_d;
    logic [DW-1:0]      dq_q, dq_d;
    logic [QW-1:0]      rem_q, rem_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic [OUT_BIT-1:0] veri_q, veri_d;
    logic [2:0]         orow_q, orow_d;
    logic [2:0]         ocol_q, ocol_d;
    logic               oson_q, oson_d;
    logic               valid_q, valid_d;
    logic               hazir_q, hazir_d;

    logic [5:0]    idx_c;
    logic [QW-1:0] tq_c;
    logic [QW-1:0] qe_c;
    logic [DW-1:0] xs_c;
    logic [DW-1:0] mag_c;
    logic [DW-1:0] dvd_c;
    logic [QW:0]   shift_c;
    logic [QW:0]   diff_c;
    logic          ge_c;

    assign idx_c = {dct_veri_row_i, dct_veri_col_i};

`ifdef QUANT_TABLE_LOAD_EN
    logic [QW-1:0] tablo_q [64];
    logic [QW-1:0] tablo_d [64];

    // Table write port, usable in any state
    always_comb begin
        tablo_d = tablo_q;
        if (tablo_yaz_i) begin
            tablo_d[tablo_adres_i] = tablo_veri_i;
        end
    end

    // Table storage, restored to the default table on reset
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            for (int i = 0; i < 64; i++) begin
                tablo_q[i] <= DEF_TABLE[i];
            end
        end else begin
            tablo_q <= tablo_d;
        end
    end

    assign tq_c = tablo_q[idx_c];
`else
    assign tq_c = DEF_TABLE[idx_c];
`endif

    // Transfer-time operand prep: divisor guard, magnitude and rounding bias
    always_comb begin
        qe_c  = (tq_c == '0) ? QW'(1) : tq_c;
        xs_c  = {dct_veri_i[IN_BIT-1], dct_veri_i};
        mag_c = dct_veri_i[IN_BIT-1] ? (~xs_c + DW'(1)) : xs_c;
        dvd_c = mag_c + DW'(qe_c >> 1);
    end

    // One restoring-division step: shift in next dividend bit, trial subtract
    always_comb begin
        shift_c = {rem_q, dq_q[DW-1]};
        diff_c  = shift_c - {1'b0, q_q};
        ge_c    = (shift_c >= {1'b0, q_q});
    end

    // Next-state and datapath control
    always_comb begin
        state_d = state_q;
        row_d   = row_q;
        col_d   = col_q;
        son_d   = son_q;
        neg_d   = neg_q;
        q_d     = q_q;
        dq_d    = dq_q;
        rem_d   = rem_q;
        cnt_d   = cnt_q;
        veri_d  = veri_q;
        orow_d  = orow_q;
        ocol_d  = ocol_q;
        oson_d  = oson_q;

        unique case (state_q)
            BOSTA: begin
                if (dct_veri_gecerli_i) begin
                    row_d   = dct_veri_row_i;
                    col_d   = dct_veri_col_i;
                    son_d   = dct_blok_son_i;
                    neg_d   = dct_veri_i[IN_BIT-1];
                    q_d     = qe_c;
                    dq_d    = dvd_c;
                    rem_d   = '0;
                    cnt_d   = '0;
                    state_d = BOL;
                end
            end
            BOL: begin
                rem_d = ge_c ? diff_c[QW-1:0] : shift_c[QW-1:0];
                dq_d  = {dq_q[DW-2:0], ge_c};
                cnt_d = cnt_q + CW'(1);
                if (cnt_q == CW'(DW - 1)) begin
                    state_d = SONUC;
                end
            end
            SONUC: begin
                if (neg_q) begin
                    veri_d = (dq_q > NEG_LIM) ? OUT_MIN : OUT_BIT'(~dq_q + DW'(1));
                end else begin
                    veri_d = (dq_q > POS_LIM) ? OUT_MAX : OUT_BIT'(dq_q);
                end
                orow_d  = row_q;
                ocol_d  = col_q;
                oson_d  = son_q;
                state_d = CIKIS;
            end
            CIKIS: begin
                if (zig_veri_hazir_i) begin
                    oson_d  = 1'b0;
                    state_d = BOSTA;
                end
            end
            default: state_d = BOSTA;
        endcase

        hazir_d = (state_d == BOSTA);
        valid_d = (state_d == CIKIS);
    end

    // State, datapath and output registers
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            state_q <= BOSTA;
            row_q   <= '0;
            col_q   <= '0;
            son_q   <= 1'b0;
            neg_q   <= 1'b0;
            q_q     <= QW'(1);
            dq_q    <= '0;
            rem_q   <= '0;
            cnt_q   <= '0;
            veri_q  <= '0;
            orow_q  <= '0;
            ocol_q  <= '0;
            oson_q  <= 1'b0;
            valid_q <= 1'b0;
            hazir_q <= 1'b1;
        end else begin
            state_q <= state_d;
            row_q   <= row_d;
            col_q   <= col_d;
            son_q   <= son_d;
            neg_q   <= neg_d;
            q_q     <= q_d;
            dq_q    <= dq_d;
            rem_q   <= rem_d;
            cnt_q   <= cnt_d;
            veri_q  <= veri_d;
            orow_q  <= orow_d;
            ocol_q  <= ocol_d;
            oson_q  <= oson_d;
            valid_q <= valid_d;
            hazir_q <= hazir_d;
        end
    end

    assign dct_veri_hazir_o   = hazir_q;
    assign zig_veri_o         = veri_q;
    assign zig_veri_row_o     = orow_q;
    assign zig_veri_col_o     = ocol_q;
    assign zig_veri_gecerli_o = valid_q;
    assign zig_blok_son_o     = oson_q;

endmodule

// File: tb/tb_quantizer.sv
// tb_quantizer: vector table, hand sequences and random samples checked
// against an arithmetic rounding/saturation model of the quantizer.
module tb_quantizer;

    localparam int unsigned IN_BIT  = 16;
    localparam int unsigned OUT_BIT = 11;
    localparam int OUT_MAX = (1 << (OUT_BIT - 1)) - 1;
    localparam int OUT_MIN = -(1 << (OUT_BIT - 1));

    logic               clk_i = 1'b0;
    logic               rstn_i = 1'b0;
    logic [IN_BIT-1:0]  dct_veri_i = '0;
    logic [2:0]         dct_veri_row_i = '0;
    logic [2:0]         dct_veri_col_i = '0;
    logic               dct_veri_gecerli_i = 1'b0;
    logic               dct_blok_son_i = 1'b0;
    logic               dct_veri_hazir_o;
    logic [OUT_BIT-1:0] zig_veri_o;
    logic [2:0]         zig_veri_row_o;
    logic [2:0]         zig_veri_col_o;
    logic               zig_veri_gecerli_o;
    logic               zig_blok_son_o;
    logic               zig_veri_hazir_i = 1'b0;
`ifdef QUANT_TABLE_LOAD_EN
    logic               tablo_yaz_i = 1'b0;
    logic [5:0]         tablo_adres_i = '0;
    logic [7:0]         tablo_veri_i = '0;
`endif

    quantizer #(.IN_BIT(IN_BIT), .OUT_BIT(OUT_BIT)) dut (
        .clk_i              (clk_i),
        .rstn_i             (rstn_i),
        .dct_veri_i         (dct_veri_i),
        .dct_veri_row_i     (dct_veri_row_i),
        .dct_veri_col_i     (dct_veri_col_i),
        .dct_veri_gecerli_i (dct_veri_gecerli_i),
        .dct_blok_son_i     (dct_blok_son_i),
        .dct_veri_hazir_o   (dct_veri_hazir_o),
`ifdef QUANT_TABLE_LOAD_EN
        .tablo_yaz_i        (tablo_yaz_i),
        .tablo_adres_i      (tablo_adres_i),
        .tablo_veri_i       (tablo_veri_i),
`endif
        .zig_veri_o         (zig_veri_o),
        .zig_veri_row_o     (zig_veri_row_o),
        .zig_veri_col_o     (zig_veri_col_o),
        .zig_veri_gecerli_o (zig_veri_gecerli_o),
        .zig_blok_son_o     (zig_blok_son_o),
        .zig_veri_hazir_i   (zig_veri_hazir_i)
    );

    always #5 clk_i = ~clk_i;

    int total = 0;
    int bad   = 0;

    int def_tbl [64] = '{
        16, 11, 10, 16, 24,  40,  51,  61,
        12, 12, 14, 19, 26,  58,  60,  55,
        14, 13, 16, 24, 40,  57,  69,  56,
        14, 17, 22, 29, 51,  87,  80,  62,
        18, 22, 37, 56, 68,  109, 103, 77,
        24, 35, 55, 64, 81,  104, 113, 92,
        49, 64, 78, 87, 103, 121, 120, 101,
        72, 92, 95, 98, 112, 100, 103, 99
    };
    int tbl [64];

    typedef struct {
        int x;
        int row;
        int col;
        int son;
        int exp;
    } vec_t;

    vec_t vecs [12];

    task automatic chk(input string nm, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Reference: round half away from zero, then saturate
    function automatic int model(input int x, input int q);
        int qq;
        int a;
        int m;
        int r;
        qq = (q == 0) ? 1 : q;
        a  = (x < 0) ? -x : x;
        m  = (a + qq / 2) / qq;
        r  = (x < 0) ? -m : m;
        if (r > OUT_MAX) r = OUT_MAX;
        if (r < OUT_MIN) r = OUT_MIN;
        return r;
    endfunction

    task automatic wait_ready();
        int n = 0;
        while (!dct_veri_hazir_o && n < 50) begin
            @(posedge clk_i);
            #1;
            n++;
        end
        chk("in_ready", int'(dct_veri_hazir_o), 1);
    endtask

    task automatic drive(input int x, input int row, input int col, input int son);
        dct_veri_i         = IN_BIT'(x);
        dct_veri_row_i     = 3'(row);
        dct_veri_col_i     = 3'(col);
        dct_blok_son_i     = (son != 0);
        dct_veri_gecerli_i = 1'b1;
    endtask

    task automatic start(input int x, input int row, input int col, input int son);
        wait_ready();
        drive(x, row, col, son);
        @(posedge clk_i);
        #1;
        dct_veri_gecerli_i = 1'b0;
    endtask

    // Wait for the result, check it, stall a few cycles, then accept it
    task automatic collect(input int exp, input int row, input int col, input int son,
                           input int stall, input string nm);
        int n = 0;
        while (!zig_veri_gecerli_o && n < 40) begin
            @(posedge clk_i);
            #1;
            n++;
        end
        chk({nm, "/latency"}, n, 18);
        chk({nm, "/data"}, int'($signed(zig_veri_o)), exp);
        chk({nm, "/row"}, int'(zig_veri_row_o), row);
        chk({nm, "/col"}, int'(zig_veri_col_o), col);
        chk({nm, "/son"}, int'(zig_blok_son_o), son);
        for (int s = 0; s < stall; s++) begin
            dct_veri_gecerli_i = 1'b1;
            dct_veri_i         = IN_BIT'($urandom);
            @(posedge clk_i);
            #1;
            chk({nm, "/hold_valid"}, int'(zig_veri_gecerli_o), 1);
            chk({nm, "/hold_data"}, int'($signed(zig_veri_o)), exp);
            chk({nm, "/hold_son"}, int'(zig_blok_son_o), son);
            chk({nm, "/hold_in_ready"}, int'(dct_veri_hazir_o), 0);
        end
        dct_veri_gecerli_i = 1'b0;
        zig_veri_hazir_i   = 1'b1;
        @(posedge clk_i);
        #1;
        zig_veri_hazir_i = 1'b0;
        chk({nm, "/valid_drop"}, int'(zig_veri_gecerli_o), 0);
        chk({nm, "/son_drop"}, int'(zig_blok_son_o), 0);
        chk({nm, "/ready_back"}, int'(dct_veri_hazir_o), 1);
    endtask

    task automatic no_output(input int cycles, input string nm);
        int seen = 0;
        for (int c = 0; c < cycles; c++) begin
            @(posedge clk_i);
            #1;
            if (zig_veri_gecerli_o) seen++;
        end
        chk({nm, "/no_output"}, seen, 0);
    endtask

`ifdef QUANT_TABLE_LOAD_EN
    task automatic tbl_write(input int a, input int v);
        tablo_yaz_i   = 1'b1;
        tablo_adres_i = 6'(a);
        tablo_veri_i  = 8'(v);
        @(posedge clk_i);
        #1;
        tablo_yaz_i = 1'b0;
        tbl[a] = v;
    endtask
`endif

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int x;
        int row;
        int col;
        int son;
        int mode;
        logic [15:0] r16;

        tbl = def_tbl;
        vecs[0]  = '{x: 100,    row: 0, col: 0, son: 0, exp: 6};
        vecs[1]  = '{x: -100,   row: 0, col: 1, son: 0, exp: -9};
        vecs[2]  = '{x: -5,     row: 0, col: 0, son: 0, exp: 0};
        vecs[3]  = '{x: 32767,  row: 0, col: 2, son: 0, exp: 1023};
        vecs[4]  = '{x: -32768, row: 0, col: 2, son: 0, exp: -1024};
        vecs[5]  = '{x: 50,     row: 7, col: 7, son: 1, exp: 1};
        vecs[6]  = '{x: 0,      row: 3, col: 4, son: 0, exp: 0};
        vecs[7]  = '{x: 8,      row: 0, col: 0, son: 0, exp: 1};
        vecs[8]  = '{x: -8,     row: 0, col: 0, son: 1, exp: -1};
        vecs[9]  = '{x: 7,      row: 0, col: 0, son: 0, exp: 0};
        vecs[10] = '{x: 1000,   row: 7, col: 7, son: 0, exp: 10};
        vecs[11] = '{x: -1000,  row: 7, col: 7, son: 1, exp: -10};

        // Reset state
        #12;
        chk("rst/valid", int'(zig_veri_gecerli_o), 0);
        chk("rst/data", int'(zig_veri_o), 0);
        chk("rst/son", int'(zig_blok_son_o), 0);
        chk("rst/row", int'(zig_veri_row_o), 0);
        chk("rst/col", int'(zig_veri_col_o), 0);
        #10;
        rstn_i = 1'b1;
        @(posedge clk_i);
        #1;
        chk("rst/in_ready", int'(dct_veri_hazir_o), 1);

        // Vector table
        for (int i = 0; i < 12; i++) begin
            start(vecs[i].x, vecs[i].row, vecs[i].col, vecs[i].son);
            collect(vecs[i].exp, vecs[i].row, vecs[i].col, vecs[i].son, i % 3,
                    $sformatf("vec%0d", i));
        end

        // Output stall of 5 cycles with input valid held high throughout
        wait_ready();
        drive(200, 1, 1, 0);
        @(posedge clk_i);
        #1;
        drive(777, 2, 2, 1);
        begin
            int n = 0;
            while (!zig_veri_gecerli_o && n < 40) begin
                @(posedge clk_i);
                #1;
                n++;
            end
            chk("stall/latency", n, 18);
        end
        chk("stall/data", int'($signed(zig_veri_o)), 17);
        for (int s = 0; s < 5; s++) begin
            @(posedge clk_i);
            #1;
            chk("stall/hold_valid", int'(zig_veri_gecerli_o), 1);
            chk("stall/hold_data", int'($signed(zig_veri_o)), 17);
            chk("stall/hold_row", int'(zig_veri_row_o), 1);
            chk("stall/hold_col", int'(zig_veri_col_o), 1);
            chk("stall/in_ready", int'(dct_veri_hazir_o), 0);
        end
        zig_veri_hazir_i = 1'b1;
        @(posedge clk_i);
        #1;
        zig_veri_hazir_i = 1'b0;
        chk("stall/release_valid", int'(zig_veri_gecerli_o), 0);
        chk("stall/release_ready", int'(dct_veri_hazir_o), 1);
        @(posedge clk_i);
        #1;
        dct_veri_gecerli_i = 1'b0;
        chk("stall/second_taken", int'(dct_veri_hazir_o), 0);
        collect(49, 2, 2, 1, 0, "stall2");
        no_output(25, "stall");

        // Reset in the middle of a division
        start(1234, 0, 0, 1);
        repeat (5) begin
            @(posedge clk_i);
            #1;
        end
        #2;
        rstn_i = 1'b0;
        #1;
        chk("midrst/valid", int'(zig_veri_gecerli_o), 0);
        chk("midrst/data", int'(zig_veri_o), 0);
        chk("midrst/son", int'(zig_blok_son_o), 0);
        #3;
        rstn_i = 1'b1;
        @(posedge clk_i);
        #1;
        chk("midrst/in_ready", int'(dct_veri_hazir_o), 1);
        no_output(30, "midrst");

`ifdef QUANT_TABLE_LOAD_EN
        // Table load: zero entry acts as divide-by-one
        tbl_write(0, 0);
        start(5, 0, 0, 0);
        collect(5, 0, 0, 0, 0, "load_q0");
        // Write in the transfer cycle only affects later samples
        wait_ready();
        drive(100, 0, 0, 0);
        tablo_yaz_i   = 1'b1;
        tablo_adres_i = 6'd0;
        tablo_veri_i  = 8'd32;
        @(posedge clk_i);
        #1;
        tablo_yaz_i        = 1'b0;
        dct_veri_gecerli_i = 1'b0;
        collect(100, 0, 0, 0, 0, "load_same_cycle");
        tbl[0] = 32;
        start(100, 0, 0, 0);
        collect(model(100, tbl[0]), 0, 0, 0, 0, "load_q32");
        // Reset restores the default table
        #2;
        rstn_i = 1'b0;
        #3;
        rstn_i = 1'b1;
        tbl = def_tbl;
        start(100, 0, 0, 0);
        collect(6, 0, 0, 0, 0, "load_restored");
`endif

        // Random samples against the reference model
        for (int i = 0; i < 40; i++) begin
            mode = int'($urandom_range(0, 3));
            r16  = 16'($urandom);
            case (mode)
                0: x = int'($signed(r16));
                1: x = int'($urandom_range(0, 600)) - 300;
                2: x = ($urandom_range(0, 1) != 0) ? 32767 - int'($urandom_range(0, 50))
                                                   : -32768 + int'($urandom_range(0, 50));
                default: x = 0;
            endcase
            row = int'($urandom_range(0, 7));
            col = int'($urandom_range(0, 7));
            son = int'($urandom_range(0, 1));
            start(x, row, col, son);
            collect(model(x, tbl[row * 8 + col]), row, col, son,
                    int'($urandom_range(0, 2)), $sformatf("rnd%0d", i));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
